// File: rtl/if_fetch_pkg.sv
// ============================================================================
// Module  : if_fetch_pkg
// Purpose : Shared bus widths, IF-stage state encodings and helpers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package if_fetch_pkg;

  localparam int unsigned IF_REG_BUS_LEN   = 64;
  localparam int unsigned BR_BUS_LEN       = 33;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;

  localparam logic [1:0] IF_S_IDLE = 2'd0;
  localparam logic [1:0] IF_S_REQ  = 2'd1;
  localparam logic [1:0] IF_S_WAIT = 2'd2;
  localparam logic [1:0] IF_S_HOLD = 2'd3;

  typedef struct packed {
    logic [31:0] target;
    logic        taken;
  } br_bus_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_if.sv
// ============================================================================
// Module  : if_fetch_if
// Purpose : SRAM-like instruction port (req/addr_ok/data_ok) between fetch and memory.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface if_fetch_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, wdata, addr,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, wdata, addr,
    output addr_ok, data_ok, rdata
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
// Module  : if_fetch
// Purpose : Instruction-fetch stage; PC, SRAM fetch FSM, branch redirect and
//           wrong-path discard. Optional perf counters under IF_PERF_CNT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned PERF_CNT_W = 32
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  input  wire logic                      ID_allow_in,
  input  wire logic [BR_BUS_LEN-1:0]     BR_BUS,
  output logic                           IF_valid,
  output logic                           IF_ready_go,
  output logic [IF_REG_BUS_LEN-1:0]      IFreg_bus,
  if_fetch_if.master                     inst_sram,
  output logic [PERF_CNT_W-1:0]          perf_fetch_cnt,
  output logic [PERF_CNT_W-1:0]          perf_cancel_cnt
);

  br_bus_t     br;
  logic        redir;
  logic        disc;
  logic [31:0] inst_word;

  logic [1:0]  state_q,      state_d;
  logic [31:0] fetch_pc_q,   fetch_pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_pc_q,   redir_pc_d;
  logic [31:0] inst_buf_q,   inst_buf_d;

  assign br    = br_bus_t'(BR_BUS);
  // A branch is only honoured in the cycle it actually leaves decode.
  assign redir = br.taken & ID_allow_in;
  assign disc  = redir_pend_q | redir;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    inst_buf_d   = inst_buf_q;
    case (state_q)
      IF_S_IDLE: state_d = IF_S_REQ;
      IF_S_REQ: begin
        if (redir) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = br.target;
        end
        if (inst_sram.addr_ok) state_d = IF_S_WAIT;
      end
      IF_S_WAIT: begin
        if (inst_sram.data_ok) begin
          if (disc) begin
            fetch_pc_d   = redir ? br.target : redir_pc_q;
            redir_pend_d = 1'b0;
            state_d      = IF_S_REQ;
          end else if (ID_allow_in) begin
            fetch_pc_d = next_pc(fetch_pc_q);
            state_d    = IF_S_REQ;
          end else begin
            inst_buf_d = inst_sram.rdata;
            state_d    = IF_S_HOLD;
          end
        end else if (redir) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = br.target;
        end
      end
      IF_S_HOLD: begin
        if (redir) begin
          fetch_pc_d = br.target;
          state_d    = IF_S_REQ;
        end else if (ID_allow_in) begin
          fetch_pc_d = next_pc(fetch_pc_q);
          state_d    = IF_S_REQ;
        end
      end
      default: state_d = IF_S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IF_S_IDLE;
      fetch_pc_q   <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'd0;
      inst_buf_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      inst_buf_q   <= inst_buf_d;
    end
  end

  // fetch_pc_q is the in-flight address until the response is consumed.
  assign inst_word   = (state_q == IF_S_HOLD) ? inst_buf_q : inst_sram.rdata;
  assign IF_valid    = (((state_q == IF_S_WAIT) & inst_sram.data_ok & ~disc) |
                        (state_q == IF_S_HOLD)) & ~redir;
  assign IF_ready_go = IF_valid;
  assign IFreg_bus   = {inst_word, fetch_pc_q};

  assign inst_sram.req   = (state_q == IF_S_REQ);
  assign inst_sram.addr  = fetch_pc_q;
  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'b10;
  assign inst_sram.wstrb = 4'b0000;
  assign inst_sram.wdata = 32'd0;

`ifdef IF_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] fetch_cnt_q;
  logic [PERF_CNT_W-1:0] cancel_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      cancel_cnt_q <= '0;
    end else begin
      if (inst_sram.req & inst_sram.addr_ok)
        fetch_cnt_q <= fetch_cnt_q + PERF_CNT_W'(1);
      if ((state_q == IF_S_WAIT) & inst_sram.data_ok & disc)
        cancel_cnt_q <= cancel_cnt_q + PERF_CNT_W'(1);
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_cancel_cnt = cancel_cnt_q;
`else
  assign perf_fetch_cnt  = '0;
  assign perf_cancel_cnt = '0;
`endif

endmodule

`default_nettype wire
